// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Shares the single write port of the general register file between two
// writeback sources (A: ALU result, B: load return) using round-robin
// arbitration with valid/ready handshakes. Also keeps a per-register
// pending-write scoreboard and a saturating contention counter.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-low reset
//   a_valid/a_ready/a_dest/a_data    requester A handshake and payload
//   b_valid/b_ready/b_dest/b_data    requester B handshake and payload
//   wb_hold                          blocks all grants while high
//   reg_write_en/_dest/_data         registered write port to the register file
//   sb_set_en/sb_set_dest            issue stage marks a register pending
//   sb_busy                          pending-write bit per register
//   contention_cnt                   saturating count of stalled-request cycles
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREG   = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wb_hold,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_dest,
  output logic [NREG-1:0]   sb_busy,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e            last_grant;
  grant_e            last_grant_next;
  logic              a_xfer;
  logic              b_xfer;
  logic              contend;
  logic [NREG-1:0]   sb_next;

  // Grant decision: hold blocks everything, a lone requester wins, a tie
  // goes to whoever did not win the previous tie.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!wb_hold) begin
      if (a_valid && b_valid) begin
        if (last_grant == GRANT_B) a_ready = 1'b1;
        else                       b_ready = 1'b1;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;
  assign contend = (a_valid && !a_ready) || (b_valid && !b_ready);

  // Round-robin pointer only moves when both requesters competed.
  always_comb begin
    last_grant_next = last_grant;
    if (a_valid && b_valid) begin
      if (a_xfer)      last_grant_next = GRANT_A;
      else if (b_xfer) last_grant_next = GRANT_B;
    end
  end

  // Scoreboard update: clear on the register-file capture edge, then set,
  // so a newer producer marked on the same edge stays outstanding.
  always_comb begin
    sb_next = sb_busy;
    if (reg_write_en) sb_next[reg_write_dest] = 1'b0;
    if (sb_set_en)    sb_next[sb_set_dest]    = 1'b1;
  end

  // Arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant <= GRANT_B;
    else      last_grant <= last_grant_next;
  end

  // Registered write port; dest/data hold when no transfer happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write_en <= a_xfer || b_xfer;
      if (a_xfer) begin
        reg_write_dest <= a_dest;
        reg_write_data <= a_data;
      end else if (b_xfer) begin
        reg_write_dest <= b_dest;
        reg_write_data <= b_data;
      end
    end
  end

  // Pending-write scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_busy <= '0;
    else      sb_busy <= sb_next;
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      contention_cnt <= '0;
    end else if (contend && (contention_cnt != CNT_MAX)) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule
